// File: rtl/cnn_stream_loader.sv
// cnn_stream_loader: loads data and filter word streams into bus-width write beats, then pulses start
// Optional: `define CNN_LOADER_LENGTH_CHECK_EN to check payload length against rows*cols and drive errorOut
module cnn_stream_loader #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SIZE = 4096,
    parameter int FILT_BASE = 2048,
    localparam int DIM_WIDTH = $clog2(MAX_SIZE) + 1,
    localparam int BE_WIDTH = BUS_DATA_WIDTH / 8
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    input  logic                      dataValidIn,
    input  logic                      dataLastIn,
    output logic                      dataReadyOut,
    input  logic [DATA_WIDTH-1:0]     filtIn,
    input  logic                      filtValidIn,
    input  logic                      filtLastIn,
    output logic                      filtReadyOut,
    input  logic                      accelBusyIn,
    output logic [DIM_WIDTH-1:0]      dataRowsOut,
    output logic [DIM_WIDTH-1:0]      dataColsOut,
    output logic [DIM_WIDTH-1:0]      filtRowsOut,
    output logic [DIM_WIDTH-1:0]      filtColsOut,
    output logic [BUS_ADDR_WIDTH-1:0] addrOut,
    output logic [BE_WIDTH-1:0]       wrEnOut,
    output logic [BUS_DATA_WIDTH-1:0] wrDataOut,
    output logic                      startOut,
    output logic                      errorOut
);
    localparam int NUM_WORDS = BUS_DATA_WIDTH / DATA_WIDTH;
    localparam int WE_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [3:0] {IDLE, DCOLS, DROWS, DLOAD, FCOLS, FROWS, FLOAD, DRAIN, START} state_t;

    state_t                    state_q;
    logic [LANE_W-1:0]         lane_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_DATA_WIDTH-1:0] buf_q, beat_data;
    logic [BE_WIDTH-1:0]       en_q, beat_en;
    logic                      drain_filt_q, acc, last, full, issue;
    logic [DATA_WIDTH-1:0]     word;

    assign dataReadyOut = state_q inside {DCOLS, DROWS, DLOAD} || (state_q == DRAIN && !drain_filt_q);
    assign filtReadyOut = state_q inside {FCOLS, FROWS, FLOAD} || (state_q == DRAIN && drain_filt_q);
    assign acc = dataReadyOut ? dataValidIn : filtReadyOut & filtValidIn;
    assign word = dataReadyOut ? dataIn : filtIn;
    assign last = dataReadyOut ? dataLastIn : filtLastIn;
    assign full = lane_q == LANE_W'(NUM_WORDS - 1);

    // Merge the accepted word into its lane of the pending beat
    always_comb begin
        beat_data = buf_q;
        beat_en = en_q;
        beat_data[lane_q*DATA_WIDTH +: DATA_WIDTH] = word;
        beat_en[lane_q*WE_WIDTH +: WE_WIDTH] = '1;
    end

`ifdef CNN_LOADER_LENGTH_CHECK_EN
    localparam int CW = 2 * DIM_WIDTH;
    logic [CW-1:0] count_q, cnt_nxt, exp_len, hdr_len;
    logic          hdr_bad, short_end, reach;
    assign hdr_len = CW'(word[DIM_WIDTH-1:0]) * CW'(state_q == DROWS ? dataColsOut : filtColsOut);
    assign hdr_bad = hdr_len == '0 || hdr_len > CW'(MAX_SIZE);
    assign exp_len = state_q == DLOAD ? CW'(dataRowsOut) * CW'(dataColsOut) : CW'(filtRowsOut) * CW'(filtColsOut);
    assign cnt_nxt = count_q + 1'b1;
    assign short_end = last && cnt_nxt < exp_len;
    assign reach = cnt_nxt == exp_len;
    assign issue = full | last | reach;
`else
    assign issue = full | last;
    assign errorOut = 1'b0;
`endif

    // Loader FSM: header capture, beat packing/issue and start pulse
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q <= IDLE;
            lane_q <= '0;
            addr_q <= '0;
            buf_q <= '0;
            en_q <= '0;
            drain_filt_q <= 1'b0;
            dataRowsOut <= '0;
            dataColsOut <= '0;
            filtRowsOut <= '0;
            filtColsOut <= '0;
            addrOut <= '0;
            wrEnOut <= '0;
            wrDataOut <= '0;
            startOut <= 1'b0;
`ifdef CNN_LOADER_LENGTH_CHECK_EN
            count_q <= '0;
            errorOut <= 1'b0;
`endif
        end else begin
            wrEnOut <= '0;
            startOut <= 1'b0;
            case (state_q)
                IDLE: if (!accelBusyIn && dataValidIn) state_q <= DCOLS;
                DCOLS: if (acc) begin
                    dataColsOut <= word[DIM_WIDTH-1:0];
                    state_q <= DROWS;
                end
                FCOLS: if (acc) begin
                    filtColsOut <= word[DIM_WIDTH-1:0];
                    state_q <= FROWS;
                end
                DROWS, FROWS: if (acc) begin
                    if (state_q == DROWS) dataRowsOut <= word[DIM_WIDTH-1:0];
                    else filtRowsOut <= word[DIM_WIDTH-1:0];
                    addr_q <= state_q == DROWS ? '0 : BUS_ADDR_WIDTH'(FILT_BASE);
                    lane_q <= '0;
                    en_q <= '0;
                    state_q <= state_q == DROWS ? DLOAD : FLOAD;
`ifdef CNN_LOADER_LENGTH_CHECK_EN
                    count_q <= '0;
                    if (hdr_bad) begin
                        errorOut <= 1'b1;
                        drain_filt_q <= state_q == FROWS;
                        state_q <= DRAIN;
                    end
`endif
                end
                DLOAD, FLOAD: if (acc) begin
                    buf_q <= beat_data;
                    if (issue) begin
                        wrEnOut <= beat_en;
                        wrDataOut <= beat_data;
                        addrOut <= addr_q;
                        addr_q <= addr_q + 1'b1;
                        lane_q <= '0;
                        en_q <= '0;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                        en_q <= beat_en;
                    end
                    if (last) state_q <= state_q == DLOAD ? FCOLS : START;
`ifdef CNN_LOADER_LENGTH_CHECK_EN
                    count_q <= cnt_nxt;
                    if (short_end) begin
                        errorOut <= 1'b1;
                        state_q <= IDLE;
                    end else if (reach && !last) begin
                        errorOut <= 1'b1;
                        drain_filt_q <= state_q == FLOAD;
                        state_q <= DRAIN;
                    end
`endif
                end
                DRAIN: if (acc && last) state_q <= IDLE;
                START: begin
                    startOut <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_stream_loader.sv
// tb_cnn_stream_loader: directed streams checked against a beat-list model of the loader
`timescale 1ns/1ps
module tb_cnn_stream_loader;
    localparam int NW = 2;

    logic        clkIn = 1'b0, rstIn = 1'b0;
    logic [31:0] dataIn = '0, filtIn = '0;
    logic        dataValidIn = 1'b0, dataLastIn = 1'b0, filtValidIn = 1'b0, filtLastIn = 1'b0, accelBusyIn = 1'b0;
    logic        dataReadyOut, filtReadyOut, startOut, errorOut;
    logic [12:0] dataRowsOut, dataColsOut, filtRowsOut, filtColsOut;
    logic [31:0] addrOut;
    logic [7:0]  wrEnOut;
    logic [63:0] wrDataOut;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  en;
        logic [63:0] d;
        bit          st;
    } beat_t;

    beat_t       exq[$];
    int          checks = 0, errors = 0, start_cnt = 0;
    bit          exp_start = 1'b0;
    logic [63:0] m;

    always #5 clkIn = ~clkIn;

    cnn_stream_loader dut (
        .clkIn(clkIn), .rstIn(rstIn),
        .dataIn(dataIn), .dataValidIn(dataValidIn), .dataLastIn(dataLastIn), .dataReadyOut(dataReadyOut),
        .filtIn(filtIn), .filtValidIn(filtValidIn), .filtLastIn(filtLastIn), .filtReadyOut(filtReadyOut),
        .accelBusyIn(accelBusyIn),
        .dataRowsOut(dataRowsOut), .dataColsOut(dataColsOut), .filtRowsOut(filtRowsOut), .filtColsOut(filtColsOut),
        .addrOut(addrOut), .wrEnOut(wrEnOut), .wrDataOut(wrDataOut), .startOut(startOut), .errorOut(errorOut)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beats for n payload words: lanes filled in order, one beat per NW words, last beat partial
    task automatic model(input bit f, input int n, input logic [31:0] base, input bit st);
        beat_t x;
        for (int b = 0; b * NW < n; b++) begin
            x.a = (f ? 32'd2048 : 32'd0) + b;
            x.en = '0;
            x.d = '0;
            x.st = st && (b + 1) * NW >= n;
            for (int k = 0; k < NW && b * NW + k < n; k++) begin
                x.en[k*4 +: 4] = 4'hF;
                x.d[k*32 +: 32] = base + b * NW + k;
            end
            exq.push_back(x);
        end
    endtask

    task automatic push(input bit f, input logic [31:0] w, input bit l, input int gap);
        int n = 0;
        repeat (gap) begin
            @(negedge clkIn);
            dataValidIn = 1'b0;
            filtValidIn = 1'b0;
        end
        @(negedge clkIn);
        if (f) begin
            filtIn = w; filtLastIn = l; filtValidIn = 1'b1;
        end else begin
            dataIn = w; dataLastIn = l; dataValidIn = 1'b1;
        end
        while (!(f ? filtReadyOut : dataReadyOut) && n < 100) begin
            @(negedge clkIn);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %0h never accepted", w);
        end
        @(posedge clkIn);
    endtask

    task automatic stream(input bit f, input int cols, input int rows, input int n, input logic [31:0] base,
                          input int gap, input bit busy);
        if (busy) begin
            @(negedge clkIn);
            accelBusyIn = 1'b1;
            dataIn = cols;
            dataLastIn = 1'b0;
            dataValidIn = 1'b1;
            repeat (4) begin
                @(negedge clkIn);
                chk("busy_ready", dataReadyOut, 0);
            end
            accelBusyIn = 1'b0;
            @(negedge clkIn);
            chk("busy_release_ready", dataReadyOut, 1);
            @(posedge clkIn);
        end else push(f, cols, 1'b0, gap);
        push(f, rows, 1'b0, gap);
        for (int i = 0; i < n; i++) push(f, base + i, i == n - 1, gap);
        @(negedge clkIn);
        dataValidIn = 1'b0; filtValidIn = 1'b0; dataLastIn = 1'b0; filtLastIn = 1'b0;
    endtask

    task automatic settle(input int ns);
        int n = 0;
        while (exq.size() != 0 && n < 200) begin
            @(negedge clkIn);
            n++;
        end
        repeat (4) @(negedge clkIn);
        chk("queue_drained", exq.size(), 0);
        chk("start_count", start_cnt, ns);
        start_cnt = 0;
    endtask

    task automatic rst_zero(input string nm);
        chk(nm, |{dataReadyOut, filtReadyOut, dataRowsOut, dataColsOut, filtRowsOut, filtColsOut,
                  addrOut, wrEnOut, wrDataOut, startOut, errorOut}, 0);
    endtask

    // Per-cycle compare of issued beats and the start pulse against the model
    always @(negedge clkIn) if (rstIn) begin
        beat_t b;
        chk("start_timing", startOut, exp_start);
        if (startOut) start_cnt++;
        exp_start = 1'b0;
        if (wrEnOut != 0) begin
            if (exq.size() == 0) chk("unexpected_beat", wrEnOut, 0);
            else begin
                b = exq.pop_front();
                for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{b.en[i]}};
                chk("beat_addr", addrOut, b.a);
                chk("beat_en", wrEnOut, b.en);
                chk("beat_data", wrDataOut & m, b.d & m);
                exp_start = b.st;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clkIn);
        rst_zero("reset_outputs");
        rstIn = 1'b1;
        model(0, 4, 32'hA000_0000, 0);
        model(1, 2, 32'hF000_0000, 1);
        chk("pin_d0", exq[0].d, 64'hA000_0001_A000_0000);
        chk("pin_f_addr", exq[2].a, 2048);
        chk("pin_f_start", exq[2].st, 1);
        stream(0, 2, 2, 4, 32'hA000_0000, 0, 0);
        stream(1, 2, 1, 2, 32'hF000_0000, 0, 0);
        settle(1);
        chk("data_rows", dataRowsOut, 2);
        chk("data_cols", dataColsOut, 2);
        chk("filt_rows", filtRowsOut, 1);
        chk("filt_cols", filtColsOut, 2);
        model(0, 3, 32'hB000_0000, 0);
        model(1, 1, 32'hC000_0000, 1);
        chk("pin_partial_en", exq[1].en, 8'h0F);
        chk("pin_partial_lane0", exq[1].d[31:0], 32'hB000_0002);
        stream(0, 3, 1, 3, 32'hB000_0000, 0, 0);
        stream(1, 1, 1, 1, 32'hC000_0000, 0, 0);
        settle(1);
        chk("dims_1x3", {dataRowsOut, dataColsOut}, {13'd1, 13'd3});
        model(0, 4, 32'hD000_0000, 0);
        model(1, 2, 32'hE000_0000, 1);
        stream(0, 2, 2, 4, 32'hD000_0000, 1, 0);
        stream(1, 2, 1, 2, 32'hE000_0000, 1, 0);
        settle(1);
        model(0, 2, 32'h4000_0000, 0);
        model(1, 1, 32'h5000_0000, 1);
        stream(0, 2, 1, 2, 32'h4000_0000, 0, 1);
        stream(1, 1, 1, 1, 32'h5000_0000, 0, 0);
        settle(1);
        model(0, 2, 32'h6000_0000, 0);
        stream(0, 2, 1, 2, 32'h6000_0000, 0, 0);
        push(1, 32'd1, 1'b0, 0);
        push(1, 32'd2, 1'b0, 0);
        push(1, 32'h7000_0000, 1'b0, 0);
        @(negedge clkIn);
        filtValidIn = 1'b0;
        rstIn = 1'b0;
        #1;
        rst_zero("midload_reset");
        chk("midload_queue", exq.size(), 0);
        start_cnt = 0;
        exp_start = 1'b0;
        repeat (2) @(negedge clkIn);
        rstIn = 1'b1;
        model(0, 4, 32'h8000_0000, 0);
        model(1, 2, 32'h9000_0000, 1);
        stream(0, 2, 2, 4, 32'h8000_0000, 0, 0);
        stream(1, 2, 1, 2, 32'h9000_0000, 0, 0);
        settle(1);
        chk("err_before", errorOut, 0);
`ifdef CNN_LOADER_LENGTH_CHECK_EN
        model(0, 3, 32'h1000_0000, 0);
        chk("pin_short_en", exq[1].en, 8'h0F);
        stream(0, 2, 2, 3, 32'h1000_0000, 0, 0);
        settle(0);
        chk("err_short", errorOut, 1);
        model(0, 4, 32'h2000_0000, 0);
        stream(0, 2, 2, 6, 32'h2000_0000, 0, 0);
        settle(0);
        chk("err_long", errorOut, 1);
        chk("drain_done_ready", dataReadyOut, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
